compl32_serial: RTL and testbench

//  Multi-cycle complement unit for the 32-bit ALU datapath: one's complement (bitwise NOT)
//  or two's complement negation (NOT + 1), computed LSB-first, STEP bits per cycle.

---
 rtl/compl32_serial.sv | 177 +++++++++++++++++
 tb/tb_compl32_serial.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/compl32_serial.sv
`default_nettype none
//==============================================================================
// Module      : compl32_serial
// Description : Multi-cycle complement unit for the 32-bit ALU datapath.
//               Computes the one's complement (~a) or the two's complement
//               negation (-a) of the operand LSB-first, STEP bits per cycle,
//               behind valid/ready handshakes on request and result.
//
// Parameters  : WIDTH  operand/result width in bits (default 32)
//               STEP   bits processed per cycle; must divide WIDTH
//
// Ports       : clk        in   rising-edge clock
//               rst        in   synchronous active-high reset
//               in_valid   in   request present on a/mode
//               in_ready   out  unit can accept a request (IDLE only)
//               a          in   operand
//               mode       in   0 = one's complement, 1 = two's complement
//               out_valid  out  result and flags valid (DONE only)
//               out_ready  in   consumer accepts the result
//               out        out  result
//               zero       out  result == 0
//               ovf        out  negation of the most-negative operand
//               busy       out  unit is not IDLE
//
// Revision    : 1.0  initial release
//==============================================================================
module compl32_serial #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    // Number of RUN cycles per operation and the counter that tracks them.
    localparam int c_BEATS = WIDTH / STEP;
    localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;

    localparam logic [c_CW-1:0]  c_LAST = c_CW'(c_BEATS - 1);
    localparam logic [WIDTH-1:0] c_MIN  = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_shift;     // operand, consumed from the LSB end
    logic [WIDTH-1:0] r_res;       // partial result, filled from the MSB end
    logic             r_carry;     // +1 carry chain; seeded with mode
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;
    logic             r_ovf;

    logic [STEP:0]    w_sum;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;

    //--------------------------------------------------------------------------
    // Datapath slice: invert the low STEP operand bits and add the running
    // carry. For one's complement the carry is seeded with 0 and can never
    // become 1, so the slice degenerates to a plain NOT.
    //--------------------------------------------------------------------------
    always_comb begin
        w_sum      = {1'b0, ~r_shift[STEP-1:0]} + {{STEP{1'b0}}, r_carry};
        // New slice enters at the top; after c_BEATS shifts the first slice
        // computed (operand LSBs) lands in the result LSBs.
        w_res_next = (r_res >> STEP) | (WIDTH'(w_sum[STEP-1:0]) << (WIDTH - STEP));
        w_last     = (r_state == S_RUN) && (r_cnt == c_LAST);
    end

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and handshake outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= a;
                        r_res   <= '0;
                        r_carry <= mode;
                        r_cnt   <= '0;
                        // Negating the most-negative value wraps back to itself.
                        r_ovf   <= mode && (a == c_MIN);
                    end
                end
                S_RUN: begin
                    r_shift <= r_shift >> STEP;
                    r_res   <= w_res_next;
                    r_carry <= w_sum[STEP];
                    r_cnt   <= r_cnt + c_CW'(1);
                    // Visible result only changes once the whole word is done;
                    // the final carry-out is simply dropped.
                    if (r_cnt == c_LAST) begin
                        r_out  <= w_res_next;
                        r_zero <= (w_res_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out  = r_out;
    assign zero = r_zero;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_compl32_serial.sv
`default_nettype none
//==============================================================================
// Module      : tb_compl32_serial
// Description : Self-checking bench for compl32_serial. Expected results are
//               pushed to a scoreboard queue when a request is issued and
//               popped when the unit presents its result. A second instance
//               built with STEP=4 checks the wide-step datapath.
// Revision    : 1.0  initial release
//==============================================================================
module tb_compl32_serial;

    localparam int c_W = 32;

    typedef struct packed {
        logic [c_W-1:0] res;
        logic           zero;
        logic           ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, mode, out_valid, out_ready;
    logic           zero, ovf, busy;
    logic [c_W-1:0] a, out;

    logic           s4_in_valid, s4_in_ready, s4_mode, s4_out_valid, s4_out_ready;
    logic           s4_zero, s4_ovf, s4_busy;
    logic [c_W-1:0] s4_a, s4_out;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    compl32_serial #(.WIDTH(c_W), .STEP(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero(zero), .ovf(ovf), .busy(busy)
    );

    compl32_serial #(.WIDTH(c_W), .STEP(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(s4_in_valid), .in_ready(s4_in_ready), .a(s4_a), .mode(s4_mode),
        .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out(s4_out),
        .zero(s4_zero), .ovf(s4_ovf), .busy(s4_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [c_W-1:0] va, input logic vm);
        exp_t e;
        e.res  = vm ? (c_W'(0) - va) : ~va;
        e.zero = (e.res == '0);
        e.ovf  = vm && (va == 32'h8000_0000);
        return e;
    endfunction

    // Issue one request; returns 1 ns after the accepting edge.
    task automatic send(input logic [c_W-1:0] va, input logic vm);
        int guard = 0;
        sb.push_back(model(va, vm));
        in_valid = 1'b1;
        a        = va;
        mode     = vm;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        mode     = 1'($urandom_range(0, 1));
    endtask

    // Wait for the result, optionally stall it, compare against the scoreboard
    // and complete the output handshake.
    task automatic recv(input int hold, input bit junk);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 200) begin
            if (lat == 3) begin
                chk("run_in_ready", 64'(in_ready), 64'd0);
                chk("run_busy", 64'(busy), 64'd1);
            end
            if (junk) begin
                in_valid = (lat == 5);
                a        = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'd32);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_out", 64'(out), 64'(e.res));
            if (junk) begin
                in_valid = 1'b1;
                a        = $urandom;
                mode     = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("out", 64'(out), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.zero));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("vld_drop", 64'(out_valid), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_out_kept", 64'(out), 64'(e.res));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int vcnt;
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; mode = 1'b0;
        s4_in_valid = 1'b0; s4_out_ready = 1'b0; s4_a = '0; s4_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        send(32'h0000_0000, 1'b0); recv(0, 1'b0);
        send(32'h0000_0001, 1'b1); recv(0, 1'b0);
        send(32'h0000_0000, 1'b1); recv(0, 1'b0);
        send(32'h8000_0000, 1'b1); recv(5, 1'b1);
        // Issued right after the previous handshake: accepted one edge later.
        send(32'h7FFF_FFFF, 1'b1); recv(0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send($urandom, 1'($urandom_range(0, 1)));
            recv($urandom_range(0, 2), 1'b1);
        end

        // Abort in the middle of RUN.
        send(32'hDEAD_BEEF, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out", 64'(out), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        void'(sb.pop_front());
        vcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
        end
        chk("abort_no_result", 64'(vcnt), 64'd0);
        send(32'h0000_0005, 1'b0); recv(1, 1'b0);

        // STEP=4 instance.
        s4_a = 32'h1234_5678; s4_mode = 1'b1; s4_in_valid = 1'b1;
        @(posedge clk); #1;
        s4_in_valid = 1'b0;
        lat = 0;
        while (!s4_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("s4_latency", 64'(lat), 64'd8);
        chk("s4_out", 64'(s4_out), 64'h0000_0000_EDCB_A988);
        chk("s4_ovf", 64'(s4_ovf), 64'd0);
        s4_out_ready = 1'b1;
        @(posedge clk); #1;
        s4_out_ready = 1'b0;
        chk("s4_vld_drop", 64'(s4_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
